iterative_divider: RTL and testbench
====================================

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 The block SHALL have parameter width, default 32, operand/result bit width (width >= 4).
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port Start_i  input  1  request; accepted only on an edge where Start_i=1 and Busy_o=0.
REQ-005 The block SHALL have port Op_i  input  2  00 DIV signed quotient, 01 DIVU, 10 REM signed remainder, 11 REMU.
REQ-006 The block SHALL have port Dividend_i  input  width  dividend, sampled only at acceptance.
REQ-007 The block SHALL have port Divisor_i  input  width  divisor, sampled only at acceptance.
REQ-008 The block SHALL have port Result_o  output  width  quotient or remainder per latched Op.
REQ-009 The block SHALL have port Busy_o  output  1  operation in progress; Start_i ignored while high.
REQ-010 The block SHALL have port Done_o  output  1  one-cycle pulse; Result_o valid in that cycle.
REQ-011 The block SHALL have port DivByZero_o  output  1  latched divisor was zero; valid with Done_o, held until next acceptance.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIXUP, DONE.
REQ-013 IDLE: on acceptance, latch Op, operands; special case -> DONE, else -> CALC with iteration counter = 0.
REQ-014 Special cases SHALL be: divisor=0, or signed op with dividend=100..0 and divisor=all ones.
REQ-015 Divisor=0 results SHALL be: quotient all ones (DIV, DIVU), remainder = dividend (REM, REMU), DivByZero_o=1.
REQ-016 Signed overflow results SHALL be: quotient = 100..0, remainder = 0, DivByZero_o=0.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle on magnitudes (absolute values for signed ops), exactly width cycles, then -> FIXUP.
REQ-018 Each CALC step SHALL use a width+1-bit partial-remainder subtraction; quotient bit = 1 when non-negative, remainder restored otherwise.
REQ-019 FIXUP SHALL negate quotient when signed op and operand signs differ, negate remainder when signed op and dividend negative (remainder sign follows dividend), then -> DONE.
REQ-020 DONE SHALL last one cycle: Done_o=1, Busy_o=0, Result_o valid, then -> IDLE; a Start_i in this cycle SHALL be accepted.
REQ-021 Latency: normal path Done_o high in the cycle after the (width+2)-th rising edge following the acceptance edge; special-case path after the 1st.
REQ-022 Busy_o SHALL be 1 in CALC and FIXUP, 0 in IDLE and DONE.
REQ-023 Result_o and DivByZero_o SHALL hold their values from Done_o until the next acceptance edge.
REQ-024 Input changes after acceptance SHALL not affect the in-flight result.
REQ-025 Start_i while Busy_o=1 SHALL be dropped, not queued.

Reset
REQ-026 rst_i=1 at a rising edge SHALL force IDLE, Result_o=0, Busy_o=0, Done_o=0, DivByZero_o=0, counter=0, from any state.
REQ-027 Reset mid-operation SHALL abort with no Done_o pulse; rst_i SHALL take priority over simultaneous Start_i.

Verification
REQ-028 DIVU 100 / 7 -> Done_o after width+2 edges (34 for width=32), Result_o=14; REMU same operands -> 2.
REQ-029 DIV -7 / 2 -> Result_o=-3 (0xFFFFFFFD); REM -7 / 2 -> -1; REM 7 / -2 -> 1.
REQ-030 DIV 5 / 0 -> Done_o after 1 edge, Result_o=0xFFFFFFFF, DivByZero_o=1; REMU 5 / 0 -> 5.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> Result_o=0x80000000 after 1 edge; REM same -> 0, DivByZero_o=0.
REQ-032 Start_i pulsed while Busy_o=1 with new operands -> ignored, original result delivered; Start_i in DONE cycle -> back-to-back acceptance.
REQ-033 rst_i asserted at CALC cycle 10 -> next cycle Busy_o=0, Result_o=0, no Done_o pulse; subsequent DIVU 9/3 -> 3.

Source files
------------

// File: rtl/iterative_divider_if.sv
// Request/response bundle for iterative_divider: operands and op code in,
// result and status flags out.
interface iterative_divider_if #(
    parameter int width = 32
);
    logic             Start_i;
    logic [1:0]       Op_i;
    logic [width-1:0] Dividend_i;
    logic [width-1:0] Divisor_i;
    logic [width-1:0] Result_o;
    logic             Busy_o;
    logic             Done_o;
    logic             DivByZero_o;

    modport master (
        output Start_i,
        output Op_i,
        output Dividend_i,
        output Divisor_i,
        input  Result_o,
        input  Busy_o,
        input  Done_o,
        input  DivByZero_o
    );

    modport slave (
        input  Start_i,
        input  Op_i,
        input  Dividend_i,
        input  Divisor_i,
        output Result_o,
        output Busy_o,
        output Done_o,
        output DivByZero_o
    );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: one shift-subtract step per cycle on operand
// magnitudes, sign fixup afterwards; zero divisor and signed overflow bypass.
module iterative_divider #(
    parameter int width = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    iterative_divider_if.slave  bus
);
    localparam int CW = $clog2(width) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic             is_rem_q;
    logic [width-1:0] q_r;
    logic [width-1:0] r_r;
    logic [width-1:0] d_r;
    logic [width-1:0] res_q;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             dbz_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             is_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic             ovf;
    logic             special;
    logic [width-1:0] min_val;
    logic [width-1:0] dvd_mag;
    logic [width-1:0] dvs_mag;
    logic [width-1:0] special_res;
    logic [width:0]   partial;
    logic [width:0]   diff;
    logic             last_step;

    assign min_val = {1'b1, {(width-1){1'b0}}};

    // Start is only honoured when not busy, i.e. in IDLE or the DONE cycle.
    assign accept    = bus.Start_i && ((state_q == IDLE) || (state_q == DONE));
    assign is_signed = ~bus.Op_i[0];
    assign dvd_neg   = is_signed & bus.Dividend_i[width-1];
    assign dvs_neg   = is_signed & bus.Divisor_i[width-1];
    assign dvs_zero  = (bus.Divisor_i == '0);
    assign ovf       = is_signed && (bus.Dividend_i == min_val) && (bus.Divisor_i == '1);
    assign special   = dvs_zero | ovf;

    // Negating the most negative value wraps to itself, which is still the
    // correct unsigned magnitude 2^(width-1).
    assign dvd_mag = dvd_neg ? (-bus.Dividend_i) : bus.Dividend_i;
    assign dvs_mag = dvs_neg ? (-bus.Divisor_i)  : bus.Divisor_i;

    always_comb begin
        special_res = '0;
        if (dvs_zero) begin
            special_res = bus.Op_i[1] ? bus.Dividend_i : '1;
        end else begin
            special_res = bus.Op_i[1] ? '0 : min_val;
        end
    end

    // Partial remainder stays below 2*divisor, so width+1 bits suffice and
    // the top bit of the difference is its sign.
    assign partial   = {r_r, q_r[width-1]};
    assign diff      = partial - {1'b0, d_r};
    assign last_step = (cnt_q == CW'(width - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.Busy_o = 1'b0;
        bus.Done_o = 1'b0;
        case (state_q)
            CALC, FIXUP: bus.Busy_o = 1'b1;
            DONE:        bus.Done_o = 1'b1;
            default: begin
                bus.Busy_o = 1'b0;
                bus.Done_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_rem_q <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
            d_r      <= '0;
            res_q    <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            is_rem_q <= bus.Op_i[1];
            q_r      <= dvd_mag;
            r_r      <= '0;
            d_r      <= dvs_mag;
            neg_q_r  <= dvd_neg ^ dvs_neg;
            neg_r_r  <= dvd_neg;
            dbz_q    <= dvs_zero;
            cnt_q    <= '0;
            if (special) begin
                res_q <= special_res;
            end
        end else if (state_q == CALC) begin
            q_r   <= {q_r[width-2:0], ~diff[width]};
            r_r   <= diff[width] ? partial[width-1:0] : diff[width-1:0];
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == FIXUP) begin
            if (is_rem_q) begin
                res_q <= neg_r_r ? (-r_r) : r_r;
            end else begin
                res_q <= neg_q_r ? (-q_r) : q_r;
            end
        end
    end

    assign bus.Result_o    = res_q;
    assign bus.DivByZero_o = dbz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random bench for iterative_divider with an expected-result
// queue filled at issue time and drained on each Done pulse.
module tb_iterative_divider;
    localparam int W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   acc_cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    iterative_divider_if #(.width(W)) bus ();

    iterative_divider #(.width(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_res(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        logic [W-1:0]        minv;
        sa   = a;
        sbv  = b;
        minv = {1'b1, {(W-1){1'b0}}};
        if (b == '0) return op[1] ? a : '1;
        if (!op[0]) begin
            if (a == minv && b == '1) return op[1] ? '0 : minv;
            return op[1] ? W'(sa % sbv) : W'(sa / sbv);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit ref_special(input logic [1:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        return (b == '0) || (!op[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; the request is accepted at the next one.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input string tag, input bit push);
        exp_t e;
        bus.Op_i       = op;
        bus.Dividend_i = a;
        bus.Divisor_i  = b;
        bus.Start_i    = 1'b1;
        acc_cyc        = cyc + 1;
        if (push) begin
            e.res = ref_res(op, a, b);
            e.dbz = (b == '0);
            e.lat = ref_special(op, a, b) ? 1 : W + 2;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            bus.Start_i = 1'b0;
            if (bus.Done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL done_timeout: observed no Done_o expected Done_o within 100 cycles");
        end
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_result"}, bus.Result_o, e.res);
            check({e.tag, "_dbz"}, W'(bus.DivByZero_o), W'(e.dbz));
            check({e.tag, "_latency"}, W'(cyc - acc_cyc + 1), W'(e.lat));
            check({e.tag, "_busy_in_done"}, W'(bus.Busy_o), '0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           stray_done;

        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.Start_i    = 1'b0;
        bus.Op_i       = '0;
        bus.Dividend_i = '0;
        bus.Divisor_i  = '0;
        idle_cycles(3);
        rst = 1'b0;

        check("reset_result", bus.Result_o, '0);
        check("reset_busy", W'(bus.Busy_o), '0);
        check("reset_done", W'(bus.Done_o), '0);
        check("reset_dbz", W'(bus.DivByZero_o), '0);
        idle_cycles(1);

        start_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b1);
        wait_result();
        start_op(OP_REMU, 32'd100, 32'd7, "remu_100_7", 1'b1);
        wait_result();
        idle_cycles(1);
        check("done_one_cycle", W'(bus.Done_o), '0);

        start_op(OP_DIV, -32'sd7, 32'sd2, "div_m7_2", 1'b1);
        wait_result();
        start_op(OP_REM, -32'sd7, 32'sd2, "rem_m7_2", 1'b1);
        wait_result();
        start_op(OP_REM, 32'sd7, -32'sd2, "rem_7_m2", 1'b1);
        wait_result();
        start_op(OP_DIV, -32'sd100, -32'sd7, "div_m100_m7", 1'b1);
        wait_result();

        start_op(OP_DIV, 32'd5, 32'd0, "div_5_0", 1'b1);
        wait_result();
        start_op(OP_REMU, 32'd5, 32'd0, "remu_5_0", 1'b1);
        wait_result();
        idle_cycles(3);
        check("hold_result", bus.Result_o, 32'd5);
        check("hold_dbz", W'(bus.DivByZero_o), W'(1'b1));

        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
        wait_result();
        start_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b1);
        wait_result();
        start_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big", 1'b1);
        wait_result();
        idle_cycles(2);

        // A second request during the operation must be dropped.
        start_op(OP_DIVU, 32'd1000, 32'd7, "divu_busy_drop", 1'b1);
        idle_cycles(1);
        bus.Start_i = 1'b0;
        idle_cycles(5);
        check("busy_mid_calc", W'(bus.Busy_o), W'(1'b1));
        bus.Op_i       = OP_DIVU;
        bus.Dividend_i = 32'd50;
        bus.Divisor_i  = 32'd5;
        bus.Start_i    = 1'b1;
        wait_result();
        start_op(OP_REMU, 32'd1000, 32'd7, "remu_back_to_back", 1'b1);
        wait_result();

        // Abort in the middle of the iteration, with reset beating Start.
        start_op(OP_DIVU, 32'd12345, 32'd11, "aborted", 1'b0);
        idle_cycles(1);
        bus.Start_i = 1'b0;
        idle_cycles(10);
        rst = 1'b1;
        idle_cycles(1);
        check("abort_busy", W'(bus.Busy_o), '0);
        check("abort_result", bus.Result_o, '0);
        check("abort_done", W'(bus.Done_o), '0);
        start_op(OP_DIVU, 32'd77, 32'd7, "reset_vs_start", 1'b0);
        idle_cycles(1);
        rst         = 1'b0;
        bus.Start_i = 1'b0;
        check("reset_priority_busy", W'(bus.Busy_o), '0);
        stray_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.Done_o === 1'b1) stray_done = 1'b1;
        end
        check("abort_no_done", W'(stray_done), '0);
        start_op(OP_DIVU, 32'd9, 32'd3, "divu_9_3", 1'b1);
        wait_result();

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            start_op(rop, ra, rb, $sformatf("rand%0d", i), 1'b1);
            wait_result();
        end

        check("scoreboard_empty", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
